// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB completer-side bus bundle.
// Master drives the transfer and the slave answers with ready/slverr.
interface apb_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wr;
    logic                    sel;
    logic                    enable;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] strb;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    ready;
    logic                    slverr;

    modport master (
        output wr,
        output sel,
        output enable,
        output addr,
        output wdata,
        output strb,
        input  rdata,
        input  ready,
        input  slverr
    );

    modport slave (
        input  wr,
        input  sel,
        input  enable,
        input  addr,
        input  wdata,
        input  strb,
        output rdata,
        output ready,
        output slverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave with a byte-strobed word array,
// fixed wait states and error responses for illegal accesses.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input logic           clk,
    input logic           rst,
    apb_slave_mem_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int IDX   = $clog2(DEPTH);

    localparam logic [ADDR_WIDTH:0] LIMIT =
        (ADDR_WIDTH+1)'(DEPTH * BYTES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t state;
    state_t state_nxt;
    logic [3:0] wcnt;
    logic [3:0] wcnt_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic           setup;
    logic           access;
    logic           busy;
    logic           done;
    logic           misal;
    logic           oor;
    logic           illegal;
    logic           we;
    logic [IDX-1:0] idx;

    assign setup  = bus.sel & ~bus.enable;
    assign access = bus.sel & bus.enable;
    assign busy   = access & (wcnt != 4'd0);
    assign done   = access & (wcnt == 4'd0);

    // Sub-word address bits only exist for data wider than a byte.
    if (OFS > 0) begin : g_misal
        assign misal = |bus.addr[OFS-1:0];
    end else begin : g_nomisal
        assign misal = 1'b0;
    end

    assign oor     = {1'b0, bus.addr} >= LIMIT;
    assign illegal = misal | oor;
    assign idx     = bus.addr[OFS +: IDX];

    assign we = ~rst
              & (state == ACCESS)
              & done
              & bus.wr
              & ~illegal;

    // State and wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next state: setup arms the counter, access drains it.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        unique case (state)
            IDLE: begin
                if (setup) begin
                    state_nxt = ACCESS;
                    wcnt_nxt  = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                unique case (1'b1)
                    setup: begin
                        state_nxt = ACCESS;
                        wcnt_nxt  = 4'(WAIT_STATES);
                    end
                    busy: begin
                        wcnt_nxt = wcnt - 4'd1;
                    end
                    done: begin
                        state_nxt = IDLE;
                    end
                    default: begin
                        state_nxt = IDLE;
                    end
                endcase
            end
            default: begin
                state_nxt = IDLE;
                wcnt_nxt  = 4'd0;
            end
        endcase
    end

    // Completion outputs; everything is quiet unless ready is high.
    always_comb begin
        bus.ready  = 1'b0;
        bus.slverr = 1'b0;
        bus.rdata  = '0;
        if (!rst) begin
            if (state == IDLE && access) begin
                bus.ready  = 1'b1;
                bus.slverr = 1'b1;
            end else if (state == ACCESS && done) begin
                bus.ready  = 1'b1;
                bus.slverr = illegal;
                if (!bus.wr && !illegal) begin
                    bus.rdata = mem[idx];
                end
            end
        end
    end

    // Word array: cleared on reset, byte lanes written on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.strb[b]) begin
                    mem[idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: three slaves (0, 3, 2 wait states) driven by
// directed and random APB transfers against a word-array model.
module tb_apb_slave_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [3];
    logic        sel_v   [3];
    logic        en_v    [3];
    logic        wr_v    [3];
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [3:0]  strb_v  [3];
    logic [31:0] rdata_w [3];
    logic        rdy_w   [3];
    logic        err_w   [3];

    int total = 0;
    int bad   = 0;

    logic [31:0] model [3][16];

    apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].wr     = wr_v[g];
        assign bus[g].sel    = sel_v[g];
        assign bus[g].enable = en_v[g];
        assign bus[g].addr   = addr_v[g];
        assign bus[g].wdata  = wdata_v[g];
        assign bus[g].strb   = strb_v[g];
        assign rdata_w[g]    = bus[g].rdata;
        assign rdy_w[g]      = bus[g].ready;
        assign err_w[g]      = bus[g].slverr;

        apb_slave_mem #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .DEPTH      (16),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))
        ) dut (
            .clk(clk),
            .rst(rst_v[g]),
            .bus(bus[g].slave)
        );
    end

    function automatic int ws_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(int d);
        @(negedge clk);
        sel_v[d] = 1'b0;
        en_v[d]  = 1'b0;
    endtask

    task automatic xfer(int d, bit w, logic [31:0] a,
                        logic [31:0] wd, logic [3:0] st);
        logic legal;
        logic [31:0] exp;
        legal = (a[1:0] == 2'b00) && (a < 32'd64);
        exp   = legal ? model[d][a[5:2]] : 32'd0;
        @(negedge clk);
        sel_v[d]   = 1'b1;
        en_v[d]    = 1'b0;
        wr_v[d]    = w;
        addr_v[d]  = a;
        wdata_v[d] = wd;
        strb_v[d]  = st;
        #1 check($sformatf("setup_rdy d%0d", d), 32'(rdy_w[d]), 0);
        @(negedge clk);
        en_v[d] = 1'b1;
        for (int k = 0; k < ws_of(d); k++) begin
            #1 check($sformatf("wait_rdy d%0d k%0d", d, k),
                     32'(rdy_w[d]), 0);
            @(negedge clk);
        end
        #1;
        check($sformatf("done_rdy d%0d a%h", d, a),
              32'(rdy_w[d]), 1);
        check($sformatf("slverr d%0d a%h", d, a),
              32'(err_w[d]), 32'(!legal));
        if (!w) begin
            check($sformatf("rdata d%0d a%h", d, a), rdata_w[d], exp);
        end
        if (w && legal) begin
            for (int b = 0; b < 4; b++) begin
                if (st[b]) model[d][a[5:2]][b*8 +: 8] = wd[b*8 +: 8];
            end
        end
    endtask

    initial begin
        int r;
        int wi;
        logic [31:0] a;

        for (int d = 0; d < 3; d++) begin
            rst_v[d] = 1'b1;
            sel_v[d] = 1'b0;
            en_v[d]  = 1'b0;
            wr_v[d]  = 1'b0;
            addr_v[d]  = '0;
            wdata_v[d] = '0;
            strb_v[d]  = '0;
            for (int i = 0; i < 16; i++) model[d][i] = '0;
        end

        // Outputs held at zero while in reset, even with access asserted.
        @(negedge clk);
        sel_v[0] = 1'b1;
        en_v[0]  = 1'b1;
        #1 check("rst_rdy", 32'(rdy_w[0]), 0);
        check("rst_err", 32'(err_w[0]), 0);
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_v[d] = 1'b0;
        sel_v[0] = 1'b0;
        en_v[0]  = 1'b0;
        #1 check("idle_rdy", 32'(rdy_w[0]), 0);

        // Full write then read, zero wait states.
        xfer(0, 1, 32'h8, 32'hDEADBEEF, 4'hF);
        xfer(0, 0, 32'h8, 32'h0, 4'h0);
        check("rd_deadbeef", rdata_w[0], 32'hDEADBEEF);

        // Partial strobe merge.
        xfer(0, 1, 32'h4, 32'h11223344, 4'hF);
        xfer(0, 1, 32'h4, 32'hAABBCCDD, 4'h5);
        xfer(0, 0, 32'h4, 32'h0, 4'h0);
        check("rd_partial", rdata_w[0], 32'h11BB33DD);

        // Out of range read, misaligned write, empty strobe.
        xfer(0, 0, 32'h40, 32'h0, 4'h0);
        xfer(0, 1, 32'h6, 32'hFFFFFFFF, 4'hF);
        xfer(0, 1, 32'h4, 32'hFFFFFFFF, 4'h0);
        xfer(0, 0, 32'h4, 32'h0, 4'h0);
        check("rd_after_err", rdata_w[0], 32'h11BB33DD);
        idle(0);

        // Access phase without setup.
        @(negedge clk);
        sel_v[0]   = 1'b1;
        en_v[0]    = 1'b1;
        wr_v[0]    = 1'b1;
        addr_v[0]  = 32'h4;
        wdata_v[0] = 32'h0;
        strb_v[0]  = 4'hF;
        #1 check("proto_rdy", 32'(rdy_w[0]), 1);
        check("proto_err", 32'(err_w[0]), 1);
        check("proto_rdata", rdata_w[0], 0);
        idle(0);
        xfer(0, 0, 32'h4, 32'h0, 4'h0);
        idle(0);

        // Three wait states.
        xfer(1, 1, 32'h10, 32'hCAFEF00D, 4'hF);
        xfer(1, 0, 32'h10, 32'h0, 4'h0);
        check("ws3_rd", rdata_w[1], 32'hCAFEF00D);
        idle(1);

        // Abort in the second access cycle of a write.
        @(negedge clk);
        sel_v[2]   = 1'b1;
        en_v[2]    = 1'b0;
        wr_v[2]    = 1'b1;
        addr_v[2]  = 32'h0;
        wdata_v[2] = 32'hFFFFFFFF;
        strb_v[2]  = 4'hF;
        @(negedge clk);
        en_v[2] = 1'b1;
        #1 check("abort_acc1", 32'(rdy_w[2]), 0);
        @(negedge clk);
        sel_v[2] = 1'b0;
        #1 check("abort_acc2", 32'(rdy_w[2]), 0);
        idle(2);
        xfer(2, 0, 32'h0, 32'h0, 4'h0);
        check("abort_rd", rdata_w[2], 0);
        idle(2);

        // Reset in the middle of a transfer.
        xfer(0, 1, 32'hC, 32'h12345678, 4'hF);
        @(negedge clk);
        sel_v[0]   = 1'b1;
        en_v[0]    = 1'b0;
        wdata_v[0] = 32'hAAAAAAAA;
        @(negedge clk);
        en_v[0]  = 1'b1;
        rst_v[0] = 1'b1;
        #1 check("midrst_rdy", 32'(rdy_w[0]), 0);
        check("midrst_err", 32'(err_w[0]), 0);
        check("midrst_rdata", rdata_w[0], 0);
        @(negedge clk);
        rst_v[0] = 1'b0;
        sel_v[0] = 1'b0;
        en_v[0]  = 1'b0;
        for (int i = 0; i < 16; i++) model[0][i] = '0;
        xfer(0, 0, 32'hC, 32'h0, 4'h0);
        check("rst_rd_c", rdata_w[0], 0);

        // Random traffic, mostly back-to-back.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                r  = int'($urandom_range(0, 9));
                wi = int'($urandom_range(0, 15));
                if (r == 0) begin
                    a = 32'($urandom_range(64, 300));
                end else if (r == 1) begin
                    a = 32'(wi * 4) + 32'($urandom_range(1, 3));
                end else begin
                    a = 32'(wi * 4);
                end
                xfer(d, 1'($urandom_range(0, 1)), a, $urandom(),
                     4'($urandom_range(0, 15)));
                if ($urandom_range(0, 3) == 0) idle(d);
            end
            idle(d);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

Synchronous APB slave memory that consumes APB transfers and completes them with `ready`/`slverr`. It is the downstream completer for the APB UVC back-to-back bench: the master side drives `sel`/`enable`/`addr`/`wdata`/`strb`/`wr`, and this block returns `rdata`/`ready`/`slverr`. It provides a DEPTH-word byte-strobed register array, a programmable number of wait states and error responses for illegal accesses, so the bench can close the loop on real slave behaviour.

## Interface
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width; must be 8, 16, 32 or 64.
- `DEPTH`, 16: number of DATA_WIDTH words; must be a power of two, ≥2.
- `WAIT_STATES`, 0: cycles `ready` is held low in each access phase; range 0..15.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wr`  in  1  1 = write, 0 = read.
- `sel`  in  1  slave select.
- `enable`  in  1  access-phase indicator.
- `addr`  in  ADDR_WIDTH  byte address.
- `wdata`  in  DATA_WIDTH  write data.
- `strb`  in  DATA_WIDTH/8  write byte strobes; ignored on reads.
- `rdata`  out  DATA_WIDTH  read data; valid only while `ready`=1 on a read.
- `ready`  out  1  transfer completes this cycle.
- `slverr`  out  1  error response; valid only while `ready`=1.

## Operation
- BYTES = DATA_WIDTH/8, OFS = log2(BYTES), IDX = log2(DEPTH). Word index = `addr[OFS +: IDX]`.
- Access is illegal if `addr[OFS-1:0]` ≠ 0 (misaligned) or `addr` ≥ DEPTH*BYTES (out of range). Illegal access: no memory update, `rdata`=0, `slverr`=1 at completion.
- FSM states: IDLE, ACCESS. Wait counter `wcnt` is 4 bits.
  - IDLE: on `sel`=1 & `enable`=0 (setup phase), load `wcnt`=WAIT_STATES, go ACCESS. Otherwise stay.
  - IDLE with `sel`=1 & `enable`=1 (access without setup): protocol error; same-cycle `ready`=1, `slverr`=1, `rdata`=0, no write, stay IDLE.
  - ACCESS, `sel`=1 & `enable`=1, `wcnt`≠0: `ready`=0, decrement `wcnt`.
  - ACCESS, `sel`=1 & `enable`=1, `wcnt`=0: `ready`=1; legal write updates byte lanes where `strb`[i]=1; legal read drives word on `rdata`; go IDLE.
  - ACCESS with `sel`=0 or `enable`=0 before completion: abort, no write, go IDLE. If that cycle is `sel`=1 & `enable`=0, it is treated as a fresh setup (reload `wcnt`, stay ACCESS).
- `strb`=0 on a legal write: completes with `slverr`=0, memory unchanged.
- Address/data/strobe are sampled in the completing cycle (APB holds them stable).

## Timing
- `ready`, `slverr`, `rdata` are combinational from state, `wcnt` and inputs; forced to 0 while `rst`=1 and whenever `ready`=0.
- Reset (sync, clk edge with `rst`=1): state IDLE, `wcnt`=0, all memory words 0. Reset mid-transfer aborts it; no write commits in the reset cycle.
- Transfer length = 2 + WAIT_STATES cycles (setup + access). WAIT_STATES=0: `ready`=1 in the first access cycle.
- Write data is visible to a read whose access phase starts the cycle after the write's completing edge.
- Back-to-back: a new setup in the cycle after completion is accepted with no idle gap.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to addr 0x8, strb 0xF, then read 0x8 -> each transfer 2 cycles, `ready`=1 in access cycle, `slverr`=0, `rdata`=0xDEADBEEF.
- Partial strobe: word at 0x4 = 0x11223344; write 0xAABBCCDD strb 0x5 -> read returns 0x11BB33DD.
- Errors: read 0x40 (DEPTH=16) and write 0x6 -> `ready`=1, `slverr`=1, `rdata`=0; subsequent read of 0x4 unchanged.
- WAIT_STATES=3: write then read -> `ready` low for 3 access cycles, high on the 4th; transfer 5 cycles.
- Abort: WAIT_STATES=2, drop `sel` in second access cycle of a write to 0x0 -> no `ready`, word 0x0 stays 0; next legal read returns 0.
- Reset: write 0x12345678 to 0xC, assert `rst` one cycle mid-next-transfer -> outputs 0 during reset, read 0xC afterwards returns 0.
